// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU, load and mul/div completions onto the single register-file
// write port and tracks pending long-latency destinations for decode hazard detection.
`default_nettype none

module wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [RW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [RW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [RW-1:0]   md_rd,
  input  logic [XLEN-1:0] md_data,
  input  logic            issue_long,
  input  logic [RW-1:0]   issue_rd,
  input  logic [RW-1:0]   rs1_addr,
  input  logic [RW-1:0]   rs2_addr,
  output logic            hazard,
  output logic [NREG-1:0] busy,
  output logic            reg_wr,
  output logic [RW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic            wb_err
);

  typedef enum logic {
    GNT_LD = 1'b0,
    GNT_MD = 1'b1
  } grant_e;

  grant_e            last_q, last_d;
  logic              reg_wr_q, reg_wr_d;
  logic [RW-1:0]     wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              err_q, err_d;

  logic              ld_acc, md_acc, long_acc, win;
  logic [RW-1:0]     win_rd, long_rd;
  logic [XLEN-1:0]   win_data;

  always_comb begin
    // ALU is never stalled; LD/MD only compete among themselves, alternating on contention.
    ld_ready = rst & ~alu_valid & ld_valid & (~md_valid | (last_q == GNT_MD));
    md_ready = rst & ~alu_valid & md_valid & (~ld_valid | (last_q == GNT_LD));
    ld_acc   = ld_valid & ld_ready;
    md_acc   = md_valid & md_ready;

    win      = 1'b0;
    win_rd   = '0;
    win_data = '0;
    last_d   = last_q;
    if (alu_valid) begin
      win      = 1'b1;
      win_rd   = alu_rd;
      win_data = alu_data;
    end else if (ld_acc) begin
      win      = 1'b1;
      win_rd   = ld_rd;
      win_data = ld_data;
      last_d   = GNT_LD;
    end else if (md_acc) begin
      win      = 1'b1;
      win_rd   = md_rd;
      win_data = md_data;
      last_d   = GNT_MD;
    end

    reg_wr_d  = win & (win_rd != '0);
    wr_addr_d = win ? win_rd : wr_addr_q;
    wr_data_d = win ? win_data : wr_data_q;

    long_acc = ld_acc | md_acc;
    long_rd  = ld_acc ? ld_rd : md_rd;

    // Clear first so a same-cycle issue to the same register keeps it pending.
    busy_d = busy_q;
    if (long_acc) begin
      busy_d[long_rd] = 1'b0;
    end
    if (issue_long && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    err_d = err_q
          | (long_acc & (long_rd != '0) & ~busy_q[long_rd])
          | (issue_long & busy_q[issue_rd]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q    <= GNT_MD;
      reg_wr_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      last_q    <= last_d;
      reg_wr_q  <= reg_wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign hazard  = busy_q[rs1_addr] | busy_q[rs2_addr] | (issue_long & busy_q[issue_rd]);
  assign busy    = busy_q;
  assign reg_wr  = reg_wr_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wb_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writebacks are queued when stimulus is driven
// and compared against the registered write port one cycle later.
`default_nettype none

module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        hazard;
  logic [31:0] busy;
  logic        reg_wr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wb_err;

  wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .issue_long(issue_long), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .hazard(hazard), .busy(busy),
    .reg_wr(reg_wr), .wr_addr(wr_addr), .wr_data(wr_data), .wb_err(wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;

  wb_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks readies against the currently driven inputs, queues the expected write,
  // clocks once and compares the registered write port.
  task automatic cyc(input string tag, input logic eld, input logic emd,
                     input logic ewr, input logic [4:0] ea, input logic [31:0] ed);
    wb_t e;
    wb_t g;
    #1;
    chk({tag, ".ld_ready"}, ld_ready, eld);
    chk({tag, ".md_ready"}, md_ready, emd);
    e.wr = ewr;
    e.a  = ea;
    e.d  = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({tag, ".reg_wr"},  reg_wr,  g.wr);
    chk({tag, ".wr_addr"}, wr_addr, g.a);
    chk({tag, ".wr_data"}, wr_data, g.d);
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b1;  ld_rd = 5'd5; ld_data = 32'h5;
    md_valid = 1'b0;  md_rd = '0; md_data = '0;
    issue_long = 1'b0; issue_rd = '0;
    rs1_addr = '0; rs2_addr = '0;

    // Reset state, including ld_ready held low against a valid load.
    #3;
    chk("rst.reg_wr",   reg_wr, 1'b0);
    chk("rst.wr_addr",  wr_addr, 5'd0);
    chk("rst.wr_data",  wr_data, 32'd0);
    chk("rst.busy",     busy, 32'd0);
    chk("rst.wb_err",   wb_err, 1'b0);
    chk("rst.ld_ready", ld_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ld_ready_edge", ld_ready, 1'b0);
    chk("rst.reg_wr_edge",   reg_wr, 1'b0);
    ld_valid = 1'b0;
    rst = 1'b1;

    // Plain ALU write, then idle holds address/data.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    cyc("alu5", 0, 0, 1, 5'd5, 32'h1234);
    alu_valid = 1'b0;
    cyc("idle1", 0, 0, 0, 5'd5, 32'h1234);
    chk("alu5.busy", busy, 32'd0);

    // Issue x3 then x4; LD wins the first contention after reset.
    issue_long = 1'b1; issue_rd = 5'd3;
    cyc("iss3", 0, 0, 0, 5'd5, 32'h1234);
    #1;
    chk("iss_busy.hazard", hazard, 1'b1);
    issue_rd = 5'd4;
    #1;
    chk("iss4.hazard", hazard, 1'b0);
    cyc("iss4", 0, 0, 0, 5'd5, 32'h1234);
    issue_long = 1'b0;
    chk("iss34.busy", busy, 32'h18);
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
    md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h44;
    cyc("both.ld", 1, 0, 1, 5'd3, 32'h33);
    ld_valid = 1'b0;
    chk("both.busy1", busy, 32'h10);
    cyc("both.md", 0, 1, 1, 5'd4, 32'h44);
    md_valid = 1'b0;
    chk("both.busy2", busy, 32'd0);

    // Single load for x7 with hazard tracking and no same-cycle bypass.
    issue_long = 1'b1; issue_rd = 5'd7;
    cyc("iss7", 0, 0, 0, 5'd4, 32'h44);
    issue_long = 1'b0; rs1_addr = 5'd7;
    #1;
    chk("x7.busy", busy, 32'h80);
    chk("x7.hazard", hazard, 1'b1);
    cyc("x7.wait", 0, 0, 0, 5'd4, 32'h44);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hAA;
    #1;
    chk("x7.hazard_nobypass", hazard, 1'b1);
    cyc("x7.ld", 1, 0, 1, 5'd7, 32'hAA);
    ld_valid = 1'b0;
    #1;
    chk("x7.busy_clr", busy, 32'd0);
    chk("x7.hazard_clr", hazard, 1'b0);
    chk("x7.wb_err", wb_err, 1'b0);
    rs1_addr = 5'd0;

    // ALU starves LD/MD for three cycles; then MD first since LD was granted last.
    issue_long = 1'b1; issue_rd = 5'd10;
    cyc("iss10", 0, 0, 0, 5'd7, 32'hAA);
    issue_rd = 5'd11;
    cyc("iss11", 0, 0, 0, 5'd7, 32'hAA);
    issue_long = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h10A;
    md_valid = 1'b1; md_rd = 5'd11; md_data = 32'h11B;
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'hA0 + 32'(i);
      cyc("alu3", 0, 0, 1, 5'(i), 32'hA0 + 32'(i));
    end
    alu_valid = 1'b0;
    cyc("drain.md", 0, 1, 1, 5'd11, 32'h11B);
    md_valid = 1'b0;
    cyc("drain.ld", 1, 0, 1, 5'd10, 32'h10A);
    ld_valid = 1'b0;
    chk("drain.busy", busy, 32'd0);
    chk("drain.wb_err", wb_err, 1'b0);

    // x0 write suppressed but port address/data update; stray MD writeback is an error.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    cyc("x0", 0, 0, 0, 5'd0, 32'hFFFF);
    alu_valid = 1'b0;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
    cyc("stray9", 0, 1, 1, 5'd9, 32'h99);
    md_valid = 1'b0;
    chk("stray9.wb_err", wb_err, 1'b1);
    cyc("idle2", 0, 0, 0, 5'd9, 32'h99);
    chk("sticky.wb_err", wb_err, 1'b1);

    // Set and clear of the same register in one cycle: set wins.
    issue_long = 1'b1; issue_rd = 5'd12;
    cyc("iss12", 0, 0, 0, 5'd9, 32'h99);
    ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hC1;
    cyc("setclr", 1, 0, 1, 5'd12, 32'hC1);
    issue_long = 1'b0;
    ld_data = 32'hC2;
    chk("setclr.busy", busy, 32'h1000);
    cyc("clr12", 1, 0, 1, 5'd12, 32'hC2);
    ld_valid = 1'b0;
    chk("clr12.busy", busy, 32'd0);
    issue_long = 1'b1; issue_rd = 5'd0;
    cyc("iss0", 0, 0, 0, 5'd12, 32'hC2);
    issue_long = 1'b0;
    chk("iss0.busy", busy, 32'd0);

    // Asynchronous reset in the middle of an active write cycle.
    issue_long = 1'b1; issue_rd = 5'd13;
    cyc("iss13", 0, 0, 0, 5'd12, 32'hC2);
    issue_long = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    cyc("alu6", 0, 0, 1, 5'd6, 32'h66);
    chk("alu6.busy", busy, 32'h2000);
    alu_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h55;
    #2;
    rst = 1'b0;
    #1;
    chk("arst.reg_wr",   reg_wr, 1'b0);
    chk("arst.wr_addr",  wr_addr, 5'd0);
    chk("arst.wr_data",  wr_data, 32'd0);
    chk("arst.busy",     busy, 32'd0);
    chk("arst.wb_err",   wb_err, 1'b0);
    chk("arst.ld_ready", ld_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("arst.ld_ready_edge", ld_ready, 1'b0);
    chk("arst.reg_wr_edge",   reg_wr, 1'b0);
    ld_valid = 1'b0;
    rst = 1'b1;
    cyc("post_rst", 0, 0, 0, 5'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
